// File: rtl/cursor_renderer.sv
// SVGA raster source with a cursor box painted over a background pixel stream.
// Cursor moves are queued through a valid/ready handshake and applied between frames.
module cursor_renderer #(
  parameter int         H_ACTIVE    = 800,
  parameter int         H_FP        = 40,
  parameter int         H_SYNC      = 128,
  parameter int         H_BP        = 88,
  parameter int         V_ACTIVE    = 600,
  parameter int         V_FP        = 1,
  parameter int         V_SYNC      = 4,
  parameter int         V_BP        = 23,
  parameter int         CURSOR_SIZE = 4,
  parameter logic [9:0] CURSOR_R    = 10'h3FF,
  parameter logic [9:0] CURSOR_G    = 10'h000,
  parameter logic [9:0] CURSOR_B    = 10'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] i_pos_x,
  input  logic [12:0] i_pos_y,
  input  logic        i_pos_valid,
  output logic        o_pos_ready,
  input  logic        i_cursor_en,
  input  logic [9:0]  i_R,
  input  logic [9:0]  i_G,
  input  logic [9:0]  i_B,
  output logic [12:0] o_X_pos,
  output logic [12:0] o_Y_pos,
  output logic        o_frame_start,
  output logic [9:0]  o_R,
  output logic [9:0]  o_G,
  output logic [9:0]  o_B,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] V_APPLY  = 13'(V_ACTIVE - 1);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] BOX      = 13'(CURSOR_SIZE);
  localparam logic [12:0] X_MAX    = 13'(H_ACTIVE - CURSOR_SIZE - 3);
  localparam logic [12:0] Y_MAX    = 13'(V_ACTIVE - CURSOR_SIZE - 2);

  logic [12:0] h_cnt, v_cnt;
  logic [12:0] cur_x, cur_y;
  logic [12:0] pend_x, pend_y;
  logic [12:0] clamp_x, clamp_y;
  logic        pend_valid;
  logic        line_end, frame_end, apply_cycle, pos_xfer;
  logic        active, hsync_d, vsync_d, hit;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? 13'd0 : v_cnt + 13'd1;
    end else begin
      h_cnt <= h_cnt + 13'd1;
    end
  end

  assign o_X_pos       = h_cnt;
  assign o_Y_pos       = v_cnt;
  assign o_frame_start = (h_cnt == 13'd0) && (v_cnt == 13'd0);

  assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_d = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_d = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Box occupies cur+1 .. cur+CURSOR_SIZE on both axes, matching the detector.
  assign hit = active && i_cursor_en &&
               (cur_x < h_cnt) && (h_cnt <= cur_x + BOX) &&
               (cur_y < v_cnt) && (v_cnt <= cur_y + BOX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_R       <= '0;
      o_G       <= '0;
      o_B       <= '0;
      o_hsync   <= 1'b0;
      o_vsync   <= 1'b0;
      o_blank_n <= 1'b0;
    end else begin
      o_hsync   <= hsync_d;
      o_vsync   <= vsync_d;
      o_blank_n <= active;
      if (hit) begin
        o_R <= CURSOR_R;
        o_G <= CURSOR_G;
        o_B <= CURSOR_B;
      end else if (active) begin
        o_R <= i_R;
        o_G <= i_G;
        o_B <= i_B;
      end else begin
        o_R <= '0;
        o_G <= '0;
        o_B <= '0;
      end
    end
  end

  assign clamp_x     = (i_pos_x > X_MAX) ? X_MAX : i_pos_x;
  assign clamp_y     = (i_pos_y > Y_MAX) ? Y_MAX : i_pos_y;
  assign o_pos_ready = ~pend_valid;
  assign pos_xfer    = i_pos_valid && o_pos_ready;
  assign apply_cycle = line_end && (v_cnt == V_APPLY);

  // A transfer needs an empty pending slot, so capture and apply never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_x     <= '0;
      pend_y     <= '0;
      pend_valid <= 1'b0;
      cur_x      <= H_ACT;
      cur_y      <= V_ACT;
    end else if (pos_xfer) begin
      pend_x     <= clamp_x;
      pend_y     <= clamp_y;
      pend_valid <= 1'b1;
    end else if (apply_cycle && pend_valid) begin
      cur_x      <= pend_x;
      cur_y      <= pend_y;
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cursor_renderer.sv
// Scoreboard bench for cursor_renderer: a reference model queues the expected
// response of every pixel clock and a monitor compares it against the DUT.
module tb_cursor_renderer;

  // Scaled-down raster: 56 x 28 clocks per frame.
  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 20, VF = 1, VS = 4, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] i_pos_x = '0, i_pos_y = '0;
  logic        i_pos_valid = 1'b0;
  logic        i_cursor_en = 1'b0;
  logic [9:0]  i_R = '0, i_G = '0, i_B = '0;
  logic        o_pos_ready, o_frame_start, o_hsync, o_vsync, o_blank_n;
  logic [12:0] o_X_pos, o_Y_pos;
  logic [9:0]  o_R, o_G, o_B;

  cursor_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pos_x(i_pos_x), .i_pos_y(i_pos_y), .i_pos_valid(i_pos_valid),
    .o_pos_ready(o_pos_ready), .i_cursor_en(i_cursor_en),
    .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .o_X_pos(o_X_pos), .o_Y_pos(o_Y_pos), .o_frame_start(o_frame_start),
    .o_R(o_R), .o_G(o_G), .o_B(o_B),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank_n(o_blank_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] r, g, b;
    logic       hs, vs, bl;
    int         px, py, nx, ny;
    logic       rdy, fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int red_cnt, red_minx, red_maxx, red_miny, red_maxy, bg_cnt, blanknz_cnt;
  int last_red, last_minx, last_maxx, last_miny, last_maxy, last_bg, last_blanknz;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int x, input int y);
    i_pos_x     = 13'(x);
    i_pos_y     = 13'(y);
    i_pos_valid = 1'b1;
    @(negedge clk); #2;
    i_pos_valid = 1'b0;
  endtask

  task automatic waitPos(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(o_X_pos == 13'(h) && o_Y_pos == 13'(v)) && n < 2 * FRAME);
    checkOutput("reach_pos", {o_X_pos, o_Y_pos}, {13'(h), 13'(v)});
  endtask

  task automatic checkFrame(input string name, input int red, input int x0, input int x1, input int y0, input int y1);
    checkOutput({name, "_red_count"}, 64'(last_red), 64'(red));
    if (red > 0) begin
      checkOutput({name, "_box_x"}, {32'(last_minx), 32'(last_maxx)}, {32'(x0), 32'(x1)});
      checkOutput({name, "_box_y"}, {32'(last_miny), 32'(last_maxy)}, {32'(y0), 32'(y1)});
    end
  endtask

  // Reference model: evaluates each pixel at the clock edge the DUT samples it.
  initial begin
    int mh = 0, mv = 0, mcx = HA, mcy = VA, mpx = 0, mpy = 0, dx, dy;
    bit mpend = 0, old_ready, act, hit;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mh = 0; mv = 0; mcx = HA; mcy = VA; mpend = 0;
        exp_q.delete();
      end else begin
        old_ready = !mpend;
        act = (mh < HA) && (mv < VA);
        dx  = mh - mcx;
        dy  = mv - mcy;
        hit = act && i_cursor_en && dx >= 1 && dx <= 4 && dy >= 1 && dy <= 4;
        e.r  = hit ? 10'h3FF : (act ? i_R : 10'h0);
        e.g  = hit ? 10'h000 : (act ? i_G : 10'h0);
        e.b  = hit ? 10'h000 : (act ? i_B : 10'h0);
        e.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
        e.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
        e.bl = act;
        e.px = mh;
        e.py = mv;
        if (mh == HT - 1 && mv == VA - 1 && mpend) begin
          mcx = mpx; mcy = mpy; mpend = 0;
        end
        if (i_pos_valid && old_ready) begin
          mpx = (int'(i_pos_x) > HA - 7) ? HA - 7 : int'(i_pos_x);
          mpy = (int'(i_pos_y) > VA - 6) ? VA - 6 : int'(i_pos_y);
          mpend = 1;
        end
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end
        e.nx  = mh;
        e.ny  = mv;
        e.rdy = !mpend;
        e.fs  = (mh == 0) && (mv == 0);
        exp_q.push_back(e);
      end
    end
  end

  task automatic clearStats();
    red_cnt = 0; bg_cnt = 0; blanknz_cnt = 0;
    red_minx = 9999; red_maxx = -1; red_miny = 9999; red_maxy = -1;
  endtask

  // Monitor: pops one expected response per output cycle and gathers frame stats.
  initial begin
    exp_t e;
    clearStats();
    forever begin
      @(negedge clk);
      if (!rst) begin
        clearStats();
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pixel", {o_R, o_G, o_B, o_hsync, o_vsync, o_blank_n},
                    {e.r, e.g, e.b, e.hs, e.vs, e.bl});
        checkOutput("counters", {o_X_pos, o_Y_pos}, {13'(e.nx), 13'(e.ny)});
        checkOutput("pos_ready", 64'(o_pos_ready), 64'(e.rdy));
        checkOutput("frame_start", 64'(o_frame_start), 64'(e.fs));
        if (o_R == 10'h3FF && o_G == 10'h0 && o_B == 10'h0) begin
          red_cnt++;
          if (e.px < red_minx) red_minx = e.px;
          if (e.px > red_maxx) red_maxx = e.px;
          if (e.py < red_miny) red_miny = e.py;
          if (e.py > red_maxy) red_maxy = e.py;
        end
        if (o_R == 10'h155 && o_G == 10'h0AA && o_B == 10'h011) bg_cnt++;
        if (!(e.px < HA && e.py < VA) && {o_R, o_G, o_B} != 30'h0) blanknz_cnt++;
        if (e.px == HT - 1 && e.py == VT - 1) begin
          last_red = red_cnt; last_bg = bg_cnt; last_blanknz = blanknz_cnt;
          last_minx = red_minx; last_maxx = red_maxx;
          last_miny = red_miny; last_maxy = red_maxy;
          clearStats();
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  int  hs_cnt, vs_cnt, bl_cnt, fs_cnt, hs_rises, hs_run, hs_max, bl_run, bl_max;
  int  hs_rise_x, vs_rise_x, vs_rise_y;
  bit  prev_hs, prev_vs;

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_counters", {o_X_pos, o_Y_pos}, 26'h0);
    checkOutput("reset_colour", {o_R, o_G, o_B}, 30'h0);
    checkOutput("reset_sync_blank", {o_hsync, o_vsync, o_blank_n}, 3'b000);
    checkOutput("reset_ready", 64'(o_pos_ready), 64'd1);
    checkOutput("reset_frame_start", 64'(o_frame_start), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    i_cursor_en = 1'b1;
    #1;
    checkOutput("release_x", 64'(o_X_pos), 64'd0);
    @(negedge clk); #2;
    checkOutput("first_count", {o_X_pos, o_frame_start}, {13'd1, 1'b0});

    // Mid-frame reset with a request still pending.
    waitPos(25, 10);
    applyStimulus(10, 5);
    checkOutput("pend_ready_low", 64'(o_pos_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_counters", {o_X_pos, o_Y_pos}, 26'h0);
    checkOutput("midreset_hs_blank", {o_hsync, o_blank_n}, 2'b00);
    checkOutput("midreset_ready", 64'(o_pos_ready), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrelease_start", {o_X_pos, o_frame_start}, {13'd0, 1'b1});
    @(negedge clk); #2;
    checkOutput("midrelease_count", 64'(o_X_pos), 64'd1);
    waitPos(0, 0);
    checkFrame("after_reset", 0, 0, 0, 0, 0);

    // Timing over one free-running frame.
    hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; fs_cnt = 0; hs_rises = 0;
    hs_run = 0; hs_max = 0; bl_run = 0; bl_max = 0;
    hs_rise_x = -1; vs_rise_x = -1; vs_rise_y = -1;
    prev_hs = o_hsync; prev_vs = o_vsync;
    for (int i = 0; i < FRAME; i++) begin
      if (o_hsync && !prev_hs) begin
        hs_rises++;
        if (hs_rise_x < 0) hs_rise_x = int'(o_X_pos);
      end
      if (o_vsync && !prev_vs && vs_rise_x < 0) begin
        vs_rise_x = int'(o_X_pos); vs_rise_y = int'(o_Y_pos);
      end
      hs_run = o_hsync ? hs_run + 1 : 0;
      bl_run = o_blank_n ? bl_run + 1 : 0;
      if (hs_run > hs_max) hs_max = hs_run;
      if (bl_run > bl_max) bl_max = bl_run;
      hs_cnt += int'(o_hsync); vs_cnt += int'(o_vsync);
      bl_cnt += int'(o_blank_n); fs_cnt += int'(o_frame_start);
      prev_hs = o_hsync; prev_vs = o_vsync;
      @(negedge clk); #2;
    end
    checkOutput("hsync_width", 64'(hs_max), 64'd8);
    checkOutput("hsync_total", 64'(hs_cnt), 64'(8 * VT));
    checkOutput("hsync_rise_x", 64'(hs_rise_x), 64'd45);
    checkOutput("lines_per_frame", 64'(hs_rises), 64'(VT));
    checkOutput("vsync_total", 64'(vs_cnt), 64'(4 * HT));
    checkOutput("vsync_rise", {32'(vs_rise_x), 32'(vs_rise_y)}, {32'd1, 32'd21});
    checkOutput("blank_total", 64'(bl_cnt), 64'd800);
    checkOutput("blank_line", 64'(bl_max), 64'd40);
    checkOutput("frame_start_once", 64'(fs_cnt), 64'd1);
    checkOutput("frame_period", {o_X_pos, o_Y_pos, o_frame_start}, {13'd0, 13'd0, 1'b1});
    checkFrame("timing_frame", 0, 0, 0, 0, 0);

    // Position update: frame 0 requests, frame 1 shows it.
    waitPos(0, 5);
    applyStimulus(10, 5);
    checkOutput("update_ready_fall", 64'(o_pos_ready), 64'd0);
    waitPos(HT - 1, VA - 1);
    checkOutput("apply_ready_low", 64'(o_pos_ready), 64'd0);
    @(negedge clk); #2;
    checkOutput("apply_ready_rise", 64'(o_pos_ready), 64'd1);
    waitPos(0, 0);
    checkFrame("frame0", 0, 0, 0, 0, 0);
    waitPos(0, 0);
    checkFrame("frame1", 16, 11, 14, 6, 9);

    // Clamp plus back-pressure: the second request must be dropped.
    waitPos(0, 3);
    applyStimulus(39, 19);
    checkOutput("bp_ready_low", 64'(o_pos_ready), 64'd0);
    waitPos(0, 8);
    applyStimulus(2, 2);
    checkOutput("bp_still_low", 64'(o_pos_ready), 64'd0);
    waitPos(HT - 1, VA - 1);
    @(negedge clk); #2;
    checkOutput("bp_ready_rise", 64'(o_pos_ready), 64'd1);
    waitPos(0, 0);
    checkFrame("frame2", 16, 11, 14, 6, 9);
    waitPos(0, 2);
    applyStimulus(20, 10);
    waitPos(0, 0);
    checkFrame("frame3_clamp", 16, 34, 37, 15, 18);

    // Request landing exactly on the apply cycle waits a full extra frame.
    waitPos(HT - 1, VA - 1);
    applyStimulus(5, 0);
    checkOutput("apply_cycle_capture", 64'(o_pos_ready), 64'd0);
    waitPos(0, 0);
    checkFrame("frame4", 16, 21, 24, 11, 14);
    waitPos(0, 0);
    checkFrame("frame5_hold", 16, 21, 24, 11, 14);
    waitPos(0, 0);
    checkFrame("frame6", 16, 6, 9, 1, 4);
    checkOutput("frame6_blank_zero", 64'(last_blanknz), 64'd0);

    // Passthrough with the overlay disabled.
    i_cursor_en = 1'b0;
    i_R = 10'h155; i_G = 10'h0AA; i_B = 10'h011;
    waitPos(0, 2);
    applyStimulus(10, 10);
    waitPos(0, 0);
    checkFrame("passthrough", 0, 0, 0, 0, 0);
    checkOutput("passthrough_bg", 64'(last_bg), 64'd800);
    checkOutput("passthrough_blank_zero", 64'(last_blanknz), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_renderer.md
Name: cursor_renderer

Overview:
- SVGA 800x600 raster source and cursor painter; the transmit side of the pixel stream that the cursor detector consumes.
- Generates pixel X/Y counters, sync and blank signals.
- Overlays a CURSOR_SIZE x CURSOR_SIZE box in CURSOR colour on a background pixel stream. The box uses the detector's inclusive/exclusive box convention, so a detector fed this stream recovers the same position.
- Position updates arrive over a valid/ready handshake and take effect only at a frame boundary, so a frame is never torn.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch
H_SYNC, 128, hsync width
H_BP, 88, horizontal back porch (H_TOTAL = 1056)
V_ACTIVE, 600, visible lines
V_FP, 1, vertical front porch
V_SYNC, 4, vsync width
V_BP, 23, vertical back porch (V_TOTAL = 628)
CURSOR_SIZE, 4, cursor box edge in pixels
CURSOR_R, 10'h3FF, cursor red
CURSOR_G, 10'h000, cursor green
CURSOR_B, 10'h000, cursor blue

Ports:
clk  in  1  pixel clock (40 MHz)
rst  in  1  asynchronous, active-low reset
i_pos_x  in  13  requested cursor X
i_pos_y  in  13  requested cursor Y
i_pos_valid  in  1  position request valid
o_pos_ready  out  1  renderer can accept a request
i_cursor_en  in  1  cursor overlay enable
i_R, i_G, i_B  in  10 each  background colour for the pixel currently on o_X_pos/o_Y_pos
o_X_pos  out  13  horizontal counter
o_Y_pos  out  13  vertical counter
o_frame_start  out  1  high while o_X_pos==0 and o_Y_pos==0
o_R, o_G, o_B  out  10 each  output colour
o_hsync  out  1  horizontal sync, active-high
o_vsync  out  1  vertical sync, active-high
o_blank_n  out  1  high in the active region

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-low. All state is reset by it.
- Reset values:
  - counters = 0
  - o_R/o_G/o_B = 0, o_hsync = 0, o_vsync = 0, o_blank_n = 0
  - o_pos_ready = 1, pending request cleared
  - active cursor position cur_x = 800, cur_y = 600 (off-screen, nothing drawn)
- Reset mid-frame: counters return to 0 immediately. Any pending request is discarded.
- Counters:
  - o_X_pos increments every cycle and wraps from H_TOTAL-1 to 0.
  - o_Y_pos increments on that wrap and wraps from V_TOTAL-1 to 0.
  - o_frame_start is combinational from the counters.
- Pipeline: one-cycle latency. o_R/G/B, o_hsync, o_vsync and o_blank_n at cycle n+1 describe the pixel shown on o_X_pos/o_Y_pos and i_R/G/B at cycle n. All these outputs are registered.
- Region decode (h = o_X_pos, v = o_Y_pos):
  - active = h < H_ACTIVE and v < V_ACTIVE.
  - hsync = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
  - vsync = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604.
- Cursor hit = active and i_cursor_en and cur_x < h <= cur_x+CURSOR_SIZE and cur_y < v <= cur_y+CURSOR_SIZE.
- Colour selection:
  - hit: output CURSOR_R/G/B.
  - active and not hit: output i_R/G/B.
  - not active: output 0.
- Handshake:
  - A transfer occurs on a cycle with i_pos_valid and o_pos_ready both high.
  - The transfer latches the clamped position into the pending register. o_pos_ready goes low on the next cycle.
  - While o_pos_ready is low, i_pos_valid is ignored. The pending value holds.
- Clamp, applied at capture:
  - x > H_ACTIVE-CURSOR_SIZE-3 (793) is stored as 793.
  - y > V_ACTIVE-CURSOR_SIZE-2 (594) is stored as 594.
  - This keeps the box inside the detector's capture window.
- Apply point:
  - The apply cycle is h == H_TOTAL-1 and v == V_ACTIVE-1, the last cycle of the last active line.
  - If a request is pending there, cur_x/cur_y load it at the clock edge, the pending register clears, and o_pos_ready = 1 on the following cycle.
- Transfer on the apply cycle itself: the request is captured as pending and is not applied until the next frame's apply cycle.
- Arithmetic: all comparisons are 13-bit unsigned. cur+CURSOR_SIZE cannot overflow. No clamping is needed inside the counters.
- Frame length: 1056 x 628 = 663168 cycles.

Test Plan:
- Reset mid-frame: run to h=500, v=300, then pulse rst low for 3 cycles. Required: asynchronously o_X_pos=0, o_Y_pos=0, o_hsync=0, o_blank_n=0, o_pos_ready=1. After release, o_frame_start=1, then counting restarts at 0.
- Timing: free-run two frames. Required:
  - hsync high exactly 128 cycles, rising one cycle after o_X_pos=840.
  - line period 1056; vsync high during lines 601..604.
  - o_frame_start period 663168 cycles; o_blank_n high for 800 cycles per active line.
- Update: set i_cursor_en=1, i_R=G=B=0. During frame 0 at v=100, present x=100, y=200, valid for 1 cycle. Required:
  - o_pos_ready falls next cycle.
  - frame 0 has no red pixels.
  - frame 1 has exactly 16 pixels of colour 3FF/000/000, at x 101..104, y 201..204.
  - o_pos_ready rises one cycle after the apply cycle.
- Clamp: request x=799, y=599. Required: next frame's box covers x 794..797, y 595..598.
- Passthrough and enable: i_cursor_en=0, i_R=10'h155, i_G=10'h0AA, i_B=10'h011 with a valid position. Required: every active output pixel equals 155/0AA/011; every blanking pixel is 0.
- Back-pressure: issue a second request (x=50, y=50) while o_pos_ready=0, then a third after ready returns. Required: the second request is ignored, and the box moves to the first request, then the third, one frame apart.
